// File: rtl/imm_decode_stage_if.sv
// Handshake bundle for the immediate decode stage: upstream word in, decoded entry out.
// The master drives the stage inputs; the stage itself connects through the slave modport.
interface imm_decode_stage_if #(
  parameter int XLEN = 32
) ();
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [31:0]     in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_imm_type;
  logic [4:0]      out_rd;
  logic [6:0]      out_opcode;

  modport master (
    output flush, in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_imm, out_imm_type, out_rd, out_opcode
  );

  modport slave (
    input  flush, in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_imm, out_imm_type, out_rd, out_opcode
  );
endinterface

// File: rtl/imm_decode_stage.sv
// RV32I immediate decode stage with a main register and a one-entry skid buffer.
// in_ready comes straight from the skid valid flop, so it never depends on out_ready.
module imm_decode_stage #(
  parameter int XLEN = 32
) (
  input logic               clk,
  input logic               rst,
  imm_decode_stage_if.slave bus
);
  localparam logic [2:0] T_NONE = 3'd0;
  localparam logic [2:0] T_I    = 3'd1;
  localparam logic [2:0] T_S    = 3'd2;
  localparam logic [2:0] T_B    = 3'd3;
  localparam logic [2:0] T_U    = 3'd4;
  localparam logic [2:0] T_J    = 3'd5;
  localparam logic [2:0] T_Z    = 3'd6;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [2:0]      ty;
    logic [4:0]      rd;
    logic [6:0]      op;
  } entry_t;

  entry_t          main_reg, main_next;
  entry_t          skid_reg, skid_next;
  logic            main_valid_reg, main_valid_next;
  logic            skid_valid_reg, skid_valid_next;
  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_type;
  logic [31:0]     ins;
  entry_t          new_entry;
  logic            in_fire;
  logic            out_fire;

  assign ins = bus.in_instr;

  always_comb begin
    dec_imm  = '0;
    dec_type = T_NONE;
    case (ins[6:0])
      OP_IMM, OP_LOAD, OP_JALR: begin
        dec_type = T_I;
        dec_imm  = {{(XLEN-12){ins[31]}}, ins[31:20]};
      end
      OP_STORE: begin
        dec_type = T_S;
        dec_imm  = {{(XLEN-12){ins[31]}}, ins[31:25], ins[11:7]};
      end
      OP_BRANCH: begin
        dec_type = T_B;
        dec_imm  = {{(XLEN-13){ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        dec_type = T_U;
        dec_imm  = {{(XLEN-32){ins[31]}}, ins[31:12], 12'b0};
      end
      OP_JAL: begin
        dec_type = T_J;
        dec_imm  = {{(XLEN-21){ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      OP_SYSTEM: begin
        // funct3[2] selects the CSR immediate forms, whose rs1 field is an unsigned uimm
        if (ins[14]) begin
          dec_type = T_Z;
          dec_imm  = {{(XLEN-5){1'b0}}, ins[19:15]};
        end else begin
          dec_type = T_I;
          dec_imm  = {{(XLEN-12){ins[31]}}, ins[31:20]};
        end
      end
      default: begin
        dec_type = T_NONE;
        dec_imm  = '0;
      end
    endcase
  end

  always_comb begin
    new_entry.pc  = bus.in_pc;
    new_entry.imm = dec_imm;
    new_entry.ty  = dec_type;
    new_entry.rd  = ins[11:7];
    new_entry.op  = ins[6:0];
  end

  assign in_fire  = bus.in_valid && !skid_valid_reg;
  assign out_fire = main_valid_reg && bus.out_ready;

  always_comb begin
    main_next       = main_reg;
    skid_next       = skid_reg;
    main_valid_next = main_valid_reg;
    skid_valid_next = skid_valid_reg;
    if (bus.flush) begin
      main_valid_next = 1'b0;
      skid_valid_next = 1'b0;
    end else if (!main_valid_reg || out_fire) begin
      // skid is only ever occupied while in_ready is low, so no input can race it here
      if (skid_valid_reg) begin
        main_next       = skid_reg;
        main_valid_next = 1'b1;
        skid_valid_next = 1'b0;
      end else if (in_fire) begin
        main_next       = new_entry;
        main_valid_next = 1'b1;
      end else begin
        main_valid_next = 1'b0;
      end
    end else if (in_fire) begin
      skid_next       = new_entry;
      skid_valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_reg       <= '0;
      skid_reg       <= '0;
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else begin
      main_reg       <= main_next;
      skid_reg       <= skid_next;
      main_valid_reg <= main_valid_next;
      skid_valid_reg <= skid_valid_next;
    end
  end

  assign bus.in_ready     = !skid_valid_reg;
  assign bus.out_valid    = main_valid_reg;
  assign bus.out_pc       = main_reg.pc;
  assign bus.out_imm      = main_reg.imm;
  assign bus.out_imm_type = main_reg.ty;
  assign bus.out_rd       = main_reg.rd;
  assign bus.out_opcode   = main_reg.op;
endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: directed scenarios plus random traffic against a
// queue-based reference that decodes immediates with plain arithmetic.
module tb_imm_decode_stage;
  logic clk;
  logic rst;

  imm_decode_stage_if #(.XLEN(32)) bus ();

  imm_decode_stage #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [2:0]  ty;
    logic [4:0]  rd;
    logic [6:0]  op;
  } exp_t;

  exp_t q[$];
  bit   zero_outs;
  int   n_checks;
  int   n_fail;
  int   n_xfer;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Immediates assembled from the field rules with shifts, masks and signed offsets.
  function automatic exp_t mk(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    logic signed [31:0] s;
    logic [31:0] t;
    s = ins;
    e.pc  = pc;
    e.rd  = 5'((ins >> 7) & 32'h1F);
    e.op  = 7'(ins & 32'h7F);
    e.imm = 32'h0;
    e.ty  = 3'd0;
    case (e.op)
      7'h13, 7'h03, 7'h67: begin e.ty = 3'd1; e.imm = 32'(s >>> 20); end
      7'h23: begin e.ty = 3'd2; e.imm = 32'((s >>> 25) << 5) | ((ins >> 7) & 32'h1F); end
      7'h63: begin
        e.ty = 3'd3;
        t = (((ins >> 8) & 32'hF) << 1) + (((ins >> 25) & 32'h3F) << 5) + (((ins >> 7) & 32'h1) << 11);
        e.imm = ins[31] ? t - 32'd4096 : t;
      end
      7'h37, 7'h17: begin e.ty = 3'd4; e.imm = ins & 32'hFFFFF000; end
      7'h6F: begin
        e.ty = 3'd5;
        t = (((ins >> 21) & 32'h3FF) << 1) + (((ins >> 20) & 32'h1) << 11) + (((ins >> 12) & 32'hFF) << 12);
        e.imm = ins[31] ? t - 32'h100000 : t;
      end
      7'h73: begin
        if (ins[14]) begin e.ty = 3'd6; e.imm = (ins >> 15) & 32'h1F; end
        else begin e.ty = 3'd1; e.imm = 32'(s >>> 20); end
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic check_outputs();
    chk("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
    chk("in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
    if (q.size() > 0) begin
      chk("out_pc", 64'(bus.out_pc), 64'(q[0].pc));
      chk("out_imm", 64'(bus.out_imm), 64'(q[0].imm));
      chk("out_imm_type", 64'(bus.out_imm_type), 64'(q[0].ty));
      chk("out_rd", 64'(bus.out_rd), 64'(q[0].rd));
      chk("out_opcode", 64'(bus.out_opcode), 64'(q[0].op));
    end else if (zero_outs) begin
      chk("rst_out_pc", 64'(bus.out_pc), 64'd0);
      chk("rst_out_imm", 64'(bus.out_imm), 64'd0);
      chk("rst_out_imm_type", 64'(bus.out_imm_type), 64'd0);
      chk("rst_out_rd", 64'(bus.out_rd), 64'd0);
      chk("rst_out_opcode", 64'(bus.out_opcode), 64'd0);
    end
  endtask

  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl, input logic r);
    bit rdy;
    exp_t e;
    bus.in_valid  = v;
    bus.in_instr  = ins;
    bus.in_pc     = pc;
    bus.out_ready = ordy;
    bus.flush     = fl;
    rst           = r;
    @(posedge clk);
    if (r) begin
      q.delete();
      zero_outs = 1'b1;
    end else if (fl) begin
      q.delete();
    end else begin
      rdy = (q.size() < 2);
      if (q.size() > 0 && ordy) begin
        e = q.pop_front();
        n_xfer++;
        $display("xfer %0d: pc=%08h imm=%08h type=%0d rd=%0d op=%02h", n_xfer, e.pc, e.imm, e.ty, e.rd, e.op);
      end
      if (v && rdy) begin
        q.push_back(mk(ins, pc));
        zero_outs = 1'b0;
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 32'h0, 32'h0, ordy, 1'b0, 1'b0);
  endtask

  logic [6:0] ops [12];
  logic [31:0] r32;
  logic [31:0] ins;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    n_xfer   = 0;
    zero_outs = 1'b1;
    ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h73, 7'h33, 7'h7F};
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0;
    bus.out_ready = 1'b0; bus.flush = 1'b0; rst = 1'b1;

    @(negedge clk);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);

    // addi x1,x0,-1
    cycle(1'b1, 32'hFFF00093, 32'h100, 1'b1, 1'b0, 1'b0);
    chk("addi_imm", 64'(bus.out_imm), 64'hFFFFFFFF);
    chk("addi_type", 64'(bus.out_imm_type), 64'd1);
    chk("addi_rd", 64'(bus.out_rd), 64'd1);

    cycle(1'b1, 32'h0000D073, 32'h104, 1'b1, 1'b0, 1'b0);
    chk("csrrwi1_imm", 64'(bus.out_imm), 64'h1);
    chk("csrrwi1_type", 64'(bus.out_imm_type), 64'd6);
    cycle(1'b1, 32'h000FD073, 32'h108, 1'b1, 1'b0, 1'b0);
    chk("csrrwi31_imm", 64'(bus.out_imm), 64'h1F);

    cycle(1'b1, 32'h800000EF, 32'h10C, 1'b1, 1'b0, 1'b0);
    chk("jal_imm", 64'(bus.out_imm), 64'hFFF00000);
    chk("jal_type", 64'(bus.out_imm_type), 64'd5);
    cycle(1'b1, 32'h12345037, 32'h110, 1'b1, 1'b0, 1'b0);
    chk("lui_imm", 64'(bus.out_imm), 64'h12345000);
    chk("lui_type", 64'(bus.out_imm_type), 64'd4);
    idle(1'b1);

    // backpressure: A then B, then drain in order
    cycle(1'b1, 32'h00500113, 32'hA00, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hFE112E23, 32'hB00, 1'b0, 1'b0, 1'b0);
    chk("skid_in_ready", 64'(bus.in_ready), 64'd0);
    chk("skid_head_pc", 64'(bus.out_pc), 64'hA00);
    idle(1'b1);
    chk("drain_a_pc", 64'(bus.out_pc), 64'hB00);
    chk("drain_a_in_ready", 64'(bus.in_ready), 64'd1);
    idle(1'b1);
    chk("drain_b_valid", 64'(bus.out_valid), 64'd0);

    // flush with both entries full and a live input
    cycle(1'b1, 32'h00100093, 32'hC00, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h00200093, 32'hC04, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h00300093, 32'hC08, 1'b1, 1'b1, 1'b0);
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
    idle(1'b1);
    idle(1'b1);

    // reset mid-stream with both entries full
    cycle(1'b1, 32'hFFF00093, 32'hD00, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h800000EF, 32'hD04, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h12345037, 32'hD08, 1'b1, 1'b1, 1'b1);
    chk("rst_full_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_full_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_full_imm", 64'(bus.out_imm), 64'd0);
    chk("rst_full_pc", 64'(bus.out_pc), 64'd0);

    for (int i = 0; i < 1500; i++) begin
      r32 = $urandom();
      ins = (r32 & 32'hFFFFFF80) | 32'(ops[$urandom_range(0, 11)]);
      cycle($urandom_range(0, 3) != 0, ins, $urandom(), $urandom_range(0, 2) != 0,
            $urandom_range(0, 40) == 0, $urandom_range(0, 150) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
